// File: rtl/fmap_stream_collector.sv
// Frame-buffer collector for a conv-layer pixel stream: raster capture, then random-access readback.
// Optional sticky drop flag o_overflow enabled by defining FMAP_COLLECT_OVF_EN.
//   state  | meaning
//   S_FILL | capturing pixels in raster order; reads ignored
//   S_FULL | complete frame held; reads served, incoming pixels dropped
module fmap_stream_collector #(
  parameter int IMG_Width  = 3,
  parameter int IMG_Height = 3,
  parameter int Datawidth  = 16,
  parameter int AddrWidth  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_clr,
  input  logic [Datawidth-1:0] i_in,
  input  logic                 i_valid_in,
  input  logic                 i_rd_en,
  input  logic [AddrWidth-1:0] i_rd_addr,
  input  logic                 i_release,
  output logic [Datawidth-1:0] o_out,
  output logic                 o_valid_out,
  output logic                 o_frame_done,
  output logic [15:0]          o_row,
  output logic [15:0]          o_col
`ifdef FMAP_COLLECT_OVF_EN
  ,
  output logic                 o_overflow
`endif
);

  localparam int NPIX = IMG_Width * IMG_Height;
  localparam logic [AddrWidth:0] NPIX_W   = (AddrWidth + 1)'(NPIX);
  localparam logic [15:0]        LAST_COL = 16'(IMG_Width - 1);
  localparam logic [15:0]        LAST_ROW = 16'(IMG_Height - 1);

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [15:0]            r_row;
  logic [15:0]            r_col;
  logic [Datawidth-1:0]   r_out;
  logic                   r_valid_out;
  logic [Datawidth-1:0]   r_buf [NPIX];
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_rd_in_range;
  logic [AddrWidth-1:0]   w_wr_addr;

  always_ff @(posedge i_clk) begin
    if (i_clr) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      S_FILL: begin
        if (i_valid_in) begin
          w_wr = 1'b1;
          if (r_row == LAST_ROW && r_col == LAST_COL) w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        w_rd = i_rd_en;
        if (i_release) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  assign w_wr_addr     = AddrWidth'(r_row * 16'(IMG_Width) + r_col);
  assign w_rd_in_range = ({1'b0, i_rd_addr} < NPIX_W);

  // Buffer is deliberately left uncleared by reset.
  always_ff @(posedge i_clk) begin
    if (w_wr && !i_clr) r_buf[w_wr_addr] <= i_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_row       <= '0;
      r_col       <= '0;
      r_out       <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_rd;
      if (w_rd) r_out <= w_rd_in_range ? r_buf[i_rd_addr] : '0;
      if (w_wr) begin
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= (r_row == LAST_ROW) ? '0 : r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
    end
  end

`ifdef FMAP_COLLECT_OVF_EN
  logic r_overflow;

  // A drop in the Release cycle itself keeps the flag set across the return to FILL.
  always_ff @(posedge i_clk) begin
    if (i_clr)                                r_overflow <= 1'b0;
    else if (r_state == S_FULL && i_valid_in) r_overflow <= 1'b1;
    else if (r_state == S_FULL && i_release)  r_overflow <= 1'b0;
  end

  assign o_overflow = r_overflow;
`endif

  assign o_out        = r_out;
  assign o_valid_out  = r_valid_out;
  assign o_frame_done = (r_state == S_FULL);
  assign o_row        = r_row;
  assign o_col        = r_col;

endmodule

// File: tb/tb_fmap_stream_collector.sv
// Directed bench for fmap_stream_collector: pixel-count frame model checked every cycle,
// plus literal expectations per scenario.
module tb_fmap_stream_collector;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] din = '0;
  logic        valid_in = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rel = 1'b0;
  logic [15:0] dout;
  logic        valid_out;
  logic        frame_done;
  logic [15:0] row;
  logic [15:0] col;
`ifdef FMAP_COLLECT_OVF_EN
  logic        ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fmap_stream_collector dut (
    .i_clk(clk), .i_clr(clr), .i_in(din), .i_valid_in(valid_in),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_release(rel),
    .o_out(dout), .o_valid_out(valid_out), .o_frame_done(frame_done),
    .o_row(row), .o_col(col)
`ifdef FMAP_COLLECT_OVF_EN
    , .o_overflow(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame model: a pixel count and a 9-entry array.
  logic [15:0] m_mem [9];
  int          m_cnt   = 0;
  bit          m_full  = 0;
  bit          m_known = 0;
  bit          m_vout  = 0;
  logic [15:0] m_out   = '0;
  bit          m_ovf   = 0;

  always @(posedge clk) begin
    if (clr) begin
      m_cnt = 0; m_full = 0; m_vout = 0; m_out = '0; m_ovf = 0; m_known = 1;
    end else begin
      m_vout = m_full && rd_en;
      if (m_vout) m_out = (rd_addr < 9) ? m_mem[rd_addr] : 16'h0000;
      if (!m_full) begin
        if (valid_in) begin
          m_mem[m_cnt] = din;
          m_cnt++;
          if (m_cnt == 9) begin m_cnt = 0; m_full = 1; end
        end
      end else begin
        if (valid_in)  m_ovf = 1;
        else if (rel)  m_ovf = 0;
        if (rel) m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("model_valid_out", 32'(valid_out), 32'(m_vout));
      check("model_out", 32'(dout), 32'(m_out));
      check("model_frame_done", 32'(frame_done), 32'(m_full));
      check("model_row", 32'(row), 32'(m_cnt / 3));
      check("model_col", 32'(col), 32'(m_cnt % 3));
`ifdef FMAP_COLLECT_OVF_EN
      check("model_overflow", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic drive(input bit v, input logic [15:0] d, input bit re,
                       input logic [3:0] a, input bit rl, input bit c);
    valid_in = v; din = d; rd_en = re; rd_addr = a; rel = rl; clr = c;
    @(posedge clk);
    #2;
    valid_in = 0; rd_en = 0; rel = 0; clr = 0;
  endtask

  task automatic idle();
    drive(0, 16'h0, 0, 4'h0, 0, 0);
  endtask

  task automatic pixel(input logic [15:0] d);
    drive(1, d, 0, 4'h0, 0, 0);
  endtask

  task automatic read_lit(input string name, input logic [3:0] a, input logic [15:0] exp);
    drive(0, 16'h0, 1, a, 0, 0);
    check({name, "_valid"}, 32'(valid_out), 32'd1);
    check(name, 32'(dout), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    // 1: reset state, back-to-back frame, readback
    drive(0, 16'h0, 0, 4'h0, 0, 1);
    drive(0, 16'h0, 0, 4'h0, 0, 1);
    check("rst_row", 32'(row), 32'd0);
    check("rst_col", 32'(col), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_out", 32'(dout), 32'd0);
    for (int i = 1; i <= 8; i++) pixel(16'(i));
    check("t1_row_before_last", 32'(row), 32'd2);
    check("t1_col_before_last", 32'(col), 32'd2);
    check("t1_done_before_last", 32'(frame_done), 32'd0);
    pixel(16'd9);
    check("t1_done_after_last", 32'(frame_done), 32'd1);
    for (int i = 0; i < 9; i++) read_lit("t1_read", 4'(i), 16'(i + 1));
    idle();
    check("t1_valid_drops", 32'(valid_out), 32'd0);
    check("t1_out_holds", 32'(dout), 32'd9);

    // 2: gapped frame
    drive(0, 16'h0, 0, 4'h0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      int gaps;
      gaps = int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) idle();
      pixel(16'h0020 + 16'(i));
      if (i == 4) begin
        check("t2_row_mid", 32'(row), 32'd1);
        check("t2_col_mid", 32'(col), 32'd2);
      end
    end
    idle(); idle();
    check("t2_done", 32'(frame_done), 32'd1);
    for (int i = 0; i < 9; i++) read_lit("t2_read", 4'(i), 16'h0020 + 16'(i));

    // 3: dropped pixel in FULL, release, new frame
    pixel(16'hFFFF);
    check("t3_drop_row", 32'(row), 32'd0);
    check("t3_drop_col", 32'(col), 32'd0);
`ifdef FMAP_COLLECT_OVF_EN
    check("t3_ovf_set", 32'(ovf), 32'd1);
`endif
    drive(0, 16'h0, 0, 4'h0, 1, 0);
    check("t3_done_cleared", 32'(frame_done), 32'd0);
`ifdef FMAP_COLLECT_OVF_EN
    check("t3_ovf_cleared", 32'(ovf), 32'd0);
`endif
    for (int i = 10; i <= 18; i++) pixel(16'(i));
    for (int i = 0; i < 9; i++) read_lit("t3_read", 4'(i), 16'(i + 10));

    // 4: CLR mid-frame, negative pixels
    drive(0, 16'h0, 0, 4'h0, 1, 0);
    for (int i = 0; i < 5; i++) pixel(16'h0100 + 16'(i));
    check("t4_col_partial", 32'(col), 32'd2);
    drive(0, 16'h0, 0, 4'h0, 0, 1);
    check("t4_row_after_clr", 32'(row), 32'd0);
    check("t4_col_after_clr", 32'(col), 32'd0);
    for (int i = 0; i < 9; i++) pixel(16'h8000 + 16'(i));
    for (int i = 0; i < 9; i++) read_lit("t4_read", 4'(i), 16'h8000 + 16'(i));

    // 5: out-of-range reads, read during FILL
    read_lit("t5_oob9", 4'd9, 16'h0000);
    read_lit("t5_oob15", 4'd15, 16'h0000);
    read_lit("t5_after_oob", 4'd8, 16'h8008);
    drive(0, 16'h0, 0, 4'h0, 1, 0);
    drive(0, 16'h0, 1, 4'd2, 0, 0);
    check("t5_fill_read_ignored", 32'(valid_out), 32'd0);
    check("t5_fill_out_holds", 32'(dout), 32'h8008);

    // 6: release + read + pixel in the same cycle
    for (int i = 0; i < 9; i++) pixel(16'd100 + 16'(i));
    drive(1, 16'h7777, 1, 4'd4, 1, 0);
    check("t6_read_on_release_valid", 32'(valid_out), 32'd1);
    check("t6_read_on_release_data", 32'(dout), 32'd104);
    check("t6_done_low", 32'(frame_done), 32'd0);
    check("t6_col_no_capture", 32'(col), 32'd0);
`ifdef FMAP_COLLECT_OVF_EN
    check("t6_ovf_set_wins", 32'(ovf), 32'd1);
`endif
    pixel(16'd200);
    check("t6_col_first", 32'(col), 32'd1);
    for (int i = 1; i < 9; i++) pixel(16'd200 + 16'(i));
    read_lit("t6_read0", 4'd0, 16'd200);
    read_lit("t6_read8", 4'd8, 16'd208);
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
